// File: rtl/mosi_spi_buffer_combined.sv
// mosi_spi_buffer_combined: buffers up to N words with per-word D/C flags and shifts them out MSB first.
// Rev 1.0 - initial release.
`default_nettype none

module mosi_spi_buffer_combined #(
  parameter int WIDTH = 8,
  parameter int N     = 8
) (
  input  logic                 i_SCK,
  input  logic                 i_RST,
  input  logic [WIDTH*N-1:0]   i_DATA,
  input  logic [N-1:0]         i_DC,
  input  logic                 i_START,
  input  logic [4:0]           i_N_transmit,
  output logic                 o_MOSI_FINAL_BYTE,
  output logic                 o_MOSI,
  output logic                 o_CS,
  output logic                 o_DC,
  output logic                 o_MOSI_FINAL_BIT
);

  localparam int WIDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int BIDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W  = WIDX_W + 1;
  localparam logic [BIDX_W-1:0] BIT_TOP = BIDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(N);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t               state, nxt_state;
  logic [WIDTH*N-1:0]   data_buf, nxt_data;
  logic [N-1:0]         dc_buf, nxt_dcv;
  logic [CNT_W-1:0]     cnt, nxt_cnt, n_clamped;
  logic [WIDX_W-1:0]    word_idx, nxt_word;
  logic [BIDX_W-1:0]    bit_idx, nxt_bit;
  logic [WIDTH-1:0]     sel_word;
  logic                 last_bit, load, shifting;
  logic                 nxt_mosi, nxt_dc, nxt_fbit, nxt_fbyte;

  always_comb begin
    n_clamped = (i_N_transmit > 5'(N)) ? CNT_MAX : CNT_W'(i_N_transmit);
    last_bit  = (state == SHIFT) && (bit_idx == '0) && (CNT_W'(word_idx) == cnt - 1'b1);
    // A new burst may start from idle or seamlessly on the final bit of the current one.
    load      = ((state == IDLE) || last_bit) && i_START && (i_N_transmit != '0);

    nxt_state = IDLE;
    nxt_data  = data_buf;
    nxt_dcv   = dc_buf;
    nxt_cnt   = cnt;
    nxt_word  = '0;
    nxt_bit   = '0;

    if (load) begin
      nxt_state = SHIFT;
      nxt_data  = i_DATA;
      nxt_dcv   = i_DC;
      nxt_cnt   = n_clamped;
      nxt_word  = '0;
      nxt_bit   = BIT_TOP;
    end else if ((state == SHIFT) && !last_bit) begin
      nxt_state = SHIFT;
      if (bit_idx == '0) begin
        nxt_word = word_idx + 1'b1;
        nxt_bit  = BIT_TOP;
      end else begin
        nxt_word = word_idx;
        nxt_bit  = bit_idx - 1'b1;
      end
    end

    sel_word = '0;
    for (int k = 0; k < N; k++) begin
      if (nxt_word == WIDX_W'(k)) sel_word = nxt_data[k*WIDTH +: WIDTH];
    end

    // Outputs are derived from the next position so they are registered alongside it.
    shifting  = (nxt_state == SHIFT);
    nxt_mosi  = shifting && sel_word[nxt_bit];
    nxt_dc    = shifting && nxt_dcv[nxt_word];
    nxt_fbit  = shifting && (nxt_bit == '0);
    nxt_fbyte = nxt_fbit && (CNT_W'(nxt_word) == nxt_cnt - 1'b1);
  end

  always_ff @(posedge i_SCK) begin
    if (i_RST) begin
      state             <= IDLE;
      data_buf          <= '0;
      dc_buf            <= '0;
      cnt               <= '0;
      word_idx          <= '0;
      bit_idx           <= '0;
      o_CS              <= 1'b1;
      o_MOSI            <= 1'b0;
      o_DC              <= 1'b0;
      o_MOSI_FINAL_BIT  <= 1'b0;
      o_MOSI_FINAL_BYTE <= 1'b0;
    end else begin
      state             <= nxt_state;
      data_buf          <= nxt_data;
      dc_buf            <= nxt_dcv;
      cnt               <= nxt_cnt;
      word_idx          <= nxt_word;
      bit_idx           <= nxt_bit;
      o_CS              <= !shifting;
      o_MOSI            <= nxt_mosi;
      o_DC              <= nxt_dc;
      o_MOSI_FINAL_BIT  <= nxt_fbit;
      o_MOSI_FINAL_BYTE <= nxt_fbyte;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mosi_spi_buffer_combined.sv
// tb_mosi_spi_buffer_combined: table of bursts plus corner sequences, per-cycle scoreboard of expected pin states.
`default_nettype none

module tb_mosi_spi_buffer_combined;

  localparam int WIDTH = 8;
  localparam int N     = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [WIDTH*N-1:0]  data;
  logic [N-1:0]        dc;
  logic                start;
  logic [4:0]          ntx;
  logic                final_byte, mosi, cs, dco, final_bit;

  always #5 clk = ~clk;

  mosi_spi_buffer_combined #(.WIDTH(WIDTH), .N(N)) dut (
    .i_SCK             (clk),
    .i_RST             (rst),
    .i_DATA            (data),
    .i_DC              (dc),
    .i_START           (start),
    .i_N_transmit      (ntx),
    .o_MOSI_FINAL_BYTE (final_byte),
    .o_MOSI            (mosi),
    .o_CS              (cs),
    .o_DC              (dco),
    .o_MOSI_FINAL_BIT  (final_bit)
  );

  typedef struct packed {
    logic cs;
    logic mosi;
    logic dc;
    logic fbit;
    logic fbyte;
  } obs_t;

  typedef struct {
    string               name;
    logic [WIDTH*N-1:0]  data;
    logic [N-1:0]        dc;
    int                  n;
    int                  gap;
  } burst_t;

  obs_t   exp_q[$];
  burst_t tbl[6];
  int     vectors     = 0;
  int     miscompares = 0;

  // One clock; compare the pins against the oldest expectation (idle when none is queued).
  task automatic step(input string tag);
    obs_t e;
    obs_t a;
    @(posedge clk);
    #1;
    e = '{cs: 1'b1, mosi: 1'b0, dc: 1'b0, fbit: 1'b0, fbyte: 1'b0};
    if (exp_q.size() > 0) e = exp_q.pop_front();
    a = '{cs: cs, mosi: mosi, dc: dco, fbit: final_bit, fbyte: final_byte};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: cs/mosi/dc/fbit/fbyte got %b required %b at %0t", tag, a, e, $time);
    end
  endtask

  task automatic push_burst(input logic [WIDTH*N-1:0] d, input logic [N-1:0] f, input int n);
    int   cnt;
    obs_t e;
    cnt = (n > N) ? N : n;
    for (int w = 0; w < cnt; w++) begin
      for (int b = WIDTH - 1; b >= 0; b--) begin
        e.cs    = 1'b0;
        e.mosi  = d[w*WIDTH + b];
        e.dc    = f[w];
        e.fbit  = (b == 0);
        e.fbyte = (b == 0) && (w == cnt - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Starts a burst and runs until its final bit is on the pins, scrambling inputs mid-burst.
  task automatic send(input burst_t v);
    int total;
    total = ((v.n > N) ? N : v.n) * WIDTH;
    data  = v.data;
    dc    = v.dc;
    ntx   = 5'(v.n);
    start = 1'b1;
    push_burst(v.data, v.dc, v.n);
    step(v.name);
    start = 1'b0;
    data  = {$urandom, $urandom};
    dc    = 8'($urandom);
    ntx   = 5'($urandom_range(0, 31));
    for (int i = 1; i < total; i++) step(v.name);
  endtask

  initial begin
    tbl[0] = '{name: "burst8",   data: 64'h7FBF_DFEF_F7FB_FDFE, dc: 8'hAA, n: 8,  gap: 3};
    tbl[1] = '{name: "b2b4",     data: 64'h1111_2222_C030_0C03, dc: 8'h0C, n: 4,  gap: 0};
    tbl[2] = '{name: "short2",   data: 64'hFFFF_FFFF_FFFF_0C03, dc: 8'h02, n: 2,  gap: 30};
    tbl[3] = '{name: "b2b3",     data: 64'h0000_0000_00A5_5A81, dc: 8'h05, n: 3,  gap: 0};
    tbl[4] = '{name: "clamp20",  data: 64'h0123_4567_89AB_CDEF, dc: 8'h96, n: 20, gap: 2};
    tbl[5] = '{name: "single1",  data: 64'hFFFF_FFFF_FFFF_FF80, dc: 8'hFE, n: 1,  gap: 0};

    rst   = 1'b1;
    data  = '0;
    dc    = '0;
    start = 1'b0;
    ntx   = '0;
    step("reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step("idle_after_reset");

    for (int t = 0; t < 6; t++) begin
      for (int g = 0; g < tbl[t].gap; g++) step("gap");
      send(tbl[t]);
    end

    // Zero-length request on the final bit: drop to idle and stay there.
    start = 1'b1;
    ntx   = 5'd0;
    data  = 64'hFFFF_FFFF_FFFF_FFFF;
    dc    = 8'hFF;
    for (int i = 0; i < 30; i++) step("zero_len");
    start = 1'b0;

    // Reset in the middle of a word aborts immediately.
    data  = 64'hFFFF_FFFF_FFFF_FFFF;
    dc    = 8'hFF;
    ntx   = 5'd8;
    start = 1'b1;
    push_burst(data, dc, 8);
    step("abort_pre");
    start = 1'b0;
    for (int i = 0; i < 10; i++) step("abort_pre");
    rst = 1'b1;
    exp_q.delete();
    step("abort");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("idle_after_abort");

    send(tbl[3]);
    step("final_idle");

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: queued expectations left %0d required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
